// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings, SRAM slave FSM states and byte-lane decode helper.
package ahb2_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    RWAIT,
    RDATA,
    ERR1,
    ERR2
  } ahb2_sram_state_t;

  // Little-endian byte-enable mask for up to 8 lanes; caller keeps the low lanes it needs.
  function automatic logic [7:0] lane_mask(input logic [2:0] lane, input logic [1:0] size);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/ahb2_slv_intf.sv
// AHB2 slave-side signal bundle; hwdata/hrdata follow DATA_WIDTH.
interface AHB2_SLV_INTF #(parameter int unsigned DATA_WIDTH = 32);
  logic                  hsel;
  logic [31:0]           haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hreadyi;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyo;
  logic [1:0]            hresp;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hreadyi,
    output hrdata, hreadyo, hresp
  );
endinterface

// File: rtl/ahb2_sram_array.sv
// Byte-enabled synchronous-write word array with combinational read port.
module ahb2_sram_array #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW/8-1:0] wbe,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

  // Backdoor access for simulation preload and inspection.
  task automatic init_mem(input logic [DW-1:0] value);
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= value;
  endtask

  task automatic init_mem_with_addr();
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= DW'(i);
  endtask

  task automatic read_word(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    data = mem[addr];
  endtask

  task automatic write_word(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    mem[addr] <= data;
  endtask

endmodule

// File: rtl/ahb2_sram_slv.sv
// AHB2 SRAM slave: legality check, lane decode, read wait-state FSM and
// write-to-read forwarding in front of ahb2_sram_array.
module ahb2_sram_slv
  import ahb2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_WAIT    = 0
) (
  input logic           clk,
  input logic           rst_n,
  AHB2_SLV_INTF.slave   ahb_if
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned LB  = $clog2(NB);
  localparam int unsigned WAW = ADDR_WIDTH - LB;

  ahb2_sram_state_t state, state_nx;
  logic [2:0]            cnt, cnt_nx;
  logic                  wr_pend;
  logic [WAW-1:0]        wr_addr, rd_addr_q, ph_addr, mem_raddr;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] mem_rdata, fwd_data, hrdata_q;
  logic                  acc, legal, size_ok, align_ok, fwd_hit, mem_we;
  logic                  hreadyo_c;
  logic [1:0]            hresp_c;
  logic [LB-1:0]         align_mask;
  logic [7:0]            be_full;
  logic                  unused_sig;

  assign ph_addr    = ahb_if.haddr[ADDR_WIDTH-1:LB];
  assign unused_sig = ^{ahb_if.haddr, ahb_if.htrans[0], be_full};

  always_comb begin
    size_ok    = ahb_if.hsize <= 3'(LB);
    align_mask = LB'((8'd1 << ahb_if.hsize) - 8'd1);
    align_ok   = (ahb_if.haddr[LB-1:0] & align_mask) == '0;
    legal      = size_ok & align_ok;
    be_full    = lane_mask(3'(ahb_if.haddr[LB-1:0]), ahb_if.hsize[1:0]);
  end

  assign acc = (state inside {IDLE, RDATA, ERR2}) & ahb_if.hsel & ahb_if.htrans[1] & ahb_if.hreadyi;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    hreadyo_c = 1'b1;
    hresp_c   = HRESP_OKAY;
    case (state)
      RWAIT: begin
        hreadyo_c = 1'b0;
        cnt_nx    = cnt - 3'd1;
        if (cnt == 3'd1) state_nx = RDATA;
      end
      ERR1: begin
        hreadyo_c = 1'b0;
        hresp_c   = HRESP_ERROR;
        state_nx  = ERR2;
      end
      default: begin
        if (state == ERR2) hresp_c = HRESP_ERROR;
        state_nx = IDLE;
        if (acc) begin
          if (!legal) begin
            state_nx = ERR1;
          end else if (!ahb_if.hwrite) begin
            if (RD_WAIT > 0) begin
              state_nx = RWAIT;
              cnt_nx   = 3'(RD_WAIT);
            end else begin
              state_nx = RDATA;
            end
          end
        end
      end
    endcase
  end

  // During wait states the read address comes from the capture register; the
  // only write that could alias it has already committed by then.
  always_comb begin
    mem_raddr = (state == RWAIT) ? rd_addr_q : ph_addr;
    fwd_hit   = wr_pend & (wr_addr == mem_raddr);
    fwd_data  = mem_rdata;
    for (int unsigned i = 0; i < NB; i++) begin
      if (fwd_hit & wr_be[i]) fwd_data[8*i +: 8] = ahb_if.hwdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_pend   <= 1'b0;
      wr_addr   <= '0;
      wr_be     <= '0;
      rd_addr_q <= '0;
      hrdata_q  <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      wr_pend <= acc & legal & ahb_if.hwrite;
      if (acc & legal & ahb_if.hwrite) begin
        wr_addr <= ph_addr;
        wr_be   <= be_full[NB-1:0];
      end
      if (acc & legal & ~ahb_if.hwrite) rd_addr_q <= ph_addr;
      hrdata_q <= (state_nx == RDATA) ? fwd_data : '0;
    end
  end

  // A write whose data phase is cut short by reset is dropped.
  assign mem_we = wr_pend & rst_n;

  ahb2_sram_array #(
    .AW(WAW),
    .DW(DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr),
    .wbe   (wr_be),
    .wdata (ahb_if.hwdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  assign ahb_if.hrdata  = hrdata_q;
  assign ahb_if.hreadyo = hreadyo_c;
  assign ahb_if.hresp   = hresp_c;

endmodule

// File: tb/tb_ahb2_sram_slv.sv
// Directed bench for ahb2_sram_slv across three configurations sharing one driven bus.
module tb_ahb2_sram_slv;
  import ahb2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  sel_v;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] hwdata;
  logic [1:0]  dut;
  logic        cur_ready;
  logic [1:0]  cur_resp;
  logic [63:0] cur_rdata;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  AHB2_SLV_INTF #(.DATA_WIDTH(32)) bus0 ();
  AHB2_SLV_INTF #(.DATA_WIDTH(32)) bus1 ();
  AHB2_SLV_INTF #(.DATA_WIDTH(64)) bus2 ();

  assign bus0.hsel = sel_v[0]; assign bus0.haddr = haddr; assign bus0.htrans = htrans;
  assign bus0.hwrite = hwrite; assign bus0.hsize = hsize; assign bus0.hwdata = hwdata[31:0];
  assign bus0.hreadyi = bus0.hreadyo;
  assign bus1.hsel = sel_v[1]; assign bus1.haddr = haddr; assign bus1.htrans = htrans;
  assign bus1.hwrite = hwrite; assign bus1.hsize = hsize; assign bus1.hwdata = hwdata[31:0];
  assign bus1.hreadyi = bus1.hreadyo;
  assign bus2.hsel = sel_v[2]; assign bus2.haddr = haddr; assign bus2.htrans = htrans;
  assign bus2.hwrite = hwrite; assign bus2.hsize = hsize; assign bus2.hwdata = hwdata;
  assign bus2.hreadyi = bus2.hreadyo;

  ahb2_sram_slv #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RD_WAIT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .ahb_if(bus0));
  ahb2_sram_slv #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RD_WAIT(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .ahb_if(bus1));
  ahb2_sram_slv #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .RD_WAIT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .ahb_if(bus2));

  always_comb begin
    case (dut)
      2'd0:    begin cur_ready = bus0.hreadyo; cur_resp = bus0.hresp; cur_rdata = {32'h0, bus0.hrdata}; end
      2'd1:    begin cur_ready = bus1.hreadyo; cur_resp = bus1.hresp; cur_rdata = {32'h0, bus1.hrdata}; end
      default: begin cur_ready = bus2.hreadyo; cur_resp = bus2.hresp; cur_rdata = bus2.hrdata; end
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
    sel_v  = 3'b001 << dut;
    haddr  = a;
    htrans = HTRANS_NONSEQ;
    hwrite = w;
    hsize  = sz;
  endtask

  task automatic bus_idle();
    sel_v  = '0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d);
    addr_phase(a, 1'b1, sz);
    tick();
    bus_idle();
    hwdata = d;
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] sz, output logic [63:0] d, output int waits);
    addr_phase(a, 1'b0, sz);
    tick();
    bus_idle();
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cur_ready) break;
      waits++;
      @(posedge clk);
      #1;
    end
    d = cur_rdata;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dut = 2'd0; haddr = '0; hsize = HSIZE_WORD; hwdata = '0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      dut = 2'(d);
      #1;
      n_checks++; if (cur_ready !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyo[%0d]: got %b expected 1", d, cur_ready); end
      n_checks++; if (cur_resp !== HRESP_OKAY) begin n_fail++; $display("FAIL reset_hresp[%0d]: got %b expected %b", d, cur_resp, HRESP_OKAY); end
      n_checks++; if (cur_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_hrdata[%0d]: got %h expected 0", d, cur_rdata); end
    end
    tick();
  endtask

  task automatic test_write_read_fwd();
    logic [63:0] d;
    int w;
    dut = 2'd0;
    addr_phase(32'h100, 1'b1, HSIZE_WORD);
    tick();
    hwdata = 64'hDEADBEEF;
    addr_phase(32'h100, 1'b0, HSIZE_WORD);
    tick();
    bus_idle();
    @(negedge clk);
    n_checks++; if (cur_rdata !== 64'hDEADBEEF) begin n_fail++; $display("FAIL fwd_word: got %h expected deadbeef", cur_rdata); end
    n_checks++; if (cur_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_hreadyo: got %b expected 1", cur_ready); end
    tick();
    @(negedge clk);
    n_checks++; if (cur_rdata !== 64'h0) begin n_fail++; $display("FAIL idle_hrdata_zero: got %h expected 0", cur_rdata); end
    tick();
    do_read(32'h100, HSIZE_WORD, d, w);
    n_checks++; if (d !== 64'hDEADBEEF) begin n_fail++; $display("FAIL mem_word: got %h expected deadbeef", d); end
    n_checks++; if (w != 0) begin n_fail++; $display("FAIL zero_wait_read: got %0d waits expected 0", w); end
  endtask

  task automatic test_byte_merge();
    logic [63:0] d;
    int w;
    dut = 2'd0;
    do_write(32'h104, HSIZE_WORD, 64'h11223344);
    addr_phase(32'h106, 1'b1, HSIZE_BYTE);
    tick();
    hwdata = 64'h00AA0000;
    addr_phase(32'h104, 1'b0, HSIZE_WORD);
    tick();
    bus_idle();
    @(negedge clk);
    n_checks++; if (cur_rdata !== 64'h11AA3344) begin n_fail++; $display("FAIL byte_merge_fwd: got %h expected 11aa3344", cur_rdata); end
    tick();
    do_write(32'h104, HSIZE_HALF, 64'h00005566);
    do_read(32'h104, HSIZE_WORD, d, w);
    n_checks++; if (d !== 64'h11AA5566) begin n_fail++; $display("FAIL half_merge: got %h expected 11aa5566", d); end
    addr_phase(32'h108, 1'b1, HSIZE_WORD);
    tick();
    hwdata = 64'hA0A0A0A0;
    addr_phase(32'h109, 1'b1, HSIZE_BYTE);
    tick();
    hwdata = 64'h00005B00;
    bus_idle();
    tick();
    do_read(32'h108, HSIZE_WORD, d, w);
    n_checks++; if (d !== 64'hA0A05BA0) begin n_fail++; $display("FAIL b2b_write_lane: got %h expected a0a05ba0", d); end
  endtask

  task automatic test_wait_states();
    int low;
    logic nz;
    dut = 2'd1;
    do_write(32'h200, HSIZE_WORD, 64'hCAFEF00D);
    do_write(32'h204, HSIZE_WORD, 64'h12345678);
    addr_phase(32'h200, 1'b0, HSIZE_WORD);
    tick();
    addr_phase(32'h204, 1'b0, HSIZE_WORD);
    low = 0; nz = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cur_ready) break;
      low++;
      if (cur_rdata !== 64'h0) nz = 1'b1;
      @(posedge clk);
      #1;
    end
    n_checks++; if (low != 3) begin n_fail++; $display("FAIL rwait_cycles_1: got %0d expected 3", low); end
    n_checks++; if (cur_rdata !== 64'hCAFEF00D) begin n_fail++; $display("FAIL rwait_data_1: got %h expected cafef00d", cur_rdata); end
    n_checks++; if (nz !== 1'b0) begin n_fail++; $display("FAIL rwait_hrdata_zero: got nonzero expected 0"); end
    tick();
    bus_idle();
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cur_ready) break;
      low++;
      @(posedge clk);
      #1;
    end
    n_checks++; if (low != 3) begin n_fail++; $display("FAIL rwait_cycles_2: got %0d expected 3", low); end
    n_checks++; if (cur_rdata !== 64'h12345678) begin n_fail++; $display("FAIL rwait_data_2: got %h expected 12345678", cur_rdata); end
    tick();
  endtask

  task automatic test_error();
    logic [63:0] d;
    int w;
    dut = 2'd0;
    do_write(32'h100, HSIZE_WORD, 64'h01020304);
    addr_phase(32'h101, 1'b1, HSIZE_HALF);
    tick();
    bus_idle();
    hwdata = 64'hFFFFFFFF;
    @(negedge clk);
    n_checks++; if ({cur_ready, cur_resp} !== {1'b0, HRESP_ERROR}) begin n_fail++; $display("FAIL err1_misaligned: got rdy=%b resp=%b expected rdy=0 resp=01", cur_ready, cur_resp); end
    tick();
    @(negedge clk);
    n_checks++; if ({cur_ready, cur_resp} !== {1'b1, HRESP_ERROR}) begin n_fail++; $display("FAIL err2_misaligned: got rdy=%b resp=%b expected rdy=1 resp=01", cur_ready, cur_resp); end
    tick();
    @(negedge clk);
    n_checks++; if ({cur_ready, cur_resp} !== {1'b1, HRESP_OKAY}) begin n_fail++; $display("FAIL err_recover: got rdy=%b resp=%b expected rdy=1 resp=00", cur_ready, cur_resp); end
    tick();
    do_read(32'h100, HSIZE_WORD, d, w);
    n_checks++; if (d !== 64'h01020304) begin n_fail++; $display("FAIL err_no_write: got %h expected 01020304", d); end
    addr_phase(32'h100, 1'b0, HSIZE_DWORD);
    tick();
    bus_idle();
    @(negedge clk);
    n_checks++; if ({cur_ready, cur_resp} !== {1'b0, HRESP_ERROR}) begin n_fail++; $display("FAIL err1_oversize: got rdy=%b resp=%b expected rdy=0 resp=01", cur_ready, cur_resp); end
    tick();
    addr_phase(32'h100, 1'b0, HSIZE_WORD);
    @(negedge clk);
    n_checks++; if ({cur_ready, cur_resp} !== {1'b1, HRESP_ERROR}) begin n_fail++; $display("FAIL err2_oversize: got rdy=%b resp=%b expected rdy=1 resp=01", cur_ready, cur_resp); end
    tick();
    bus_idle();
    @(negedge clk);
    n_checks++; if (cur_rdata !== 64'h01020304) begin n_fail++; $display("FAIL read_after_err2: got %h expected 01020304", cur_rdata); end
    tick();
    sel_v = 3'b001; htrans = HTRANS_BUSY;
    tick();
    bus_idle();
    @(negedge clk);
    n_checks++; if ({cur_ready, cur_resp, cur_rdata} !== {1'b1, HRESP_OKAY, 64'h0}) begin n_fail++; $display("FAIL busy_okay: got rdy=%b resp=%b data=%h expected rdy=1 resp=00 data=0", cur_ready, cur_resp, cur_rdata); end
    tick();
  endtask

  task automatic test_wide_wrap();
    logic [63:0] d;
    int w;
    dut = 2'd2;
    do_write(32'h400, HSIZE_DWORD, 64'h0123456789ABCDEF);
    do_read(32'h000, HSIZE_DWORD, d, w);
    n_checks++; if (d !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL wrap_dword: got %h expected 0123456789abcdef", d); end
    n_checks++; if (w != 2) begin n_fail++; $display("FAIL wide_waits: got %0d expected 2", w); end
    do_write(32'h004, HSIZE_WORD, 64'h5566778800000000);
    do_read(32'h000, HSIZE_DWORD, d, w);
    n_checks++; if (d !== 64'h5566778889ABCDEF) begin n_fail++; $display("FAIL wide_upper_word: got %h expected 5566778889abcdef", d); end
    addr_phase(32'h004, 1'b0, HSIZE_DWORD);
    tick();
    bus_idle();
    @(negedge clk);
    n_checks++; if ({cur_ready, cur_resp} !== {1'b0, HRESP_ERROR}) begin n_fail++; $display("FAIL wide_misaligned: got rdy=%b resp=%b expected rdy=0 resp=01", cur_ready, cur_resp); end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    int w;
    dut = 2'd2;
    do_write(32'h010, HSIZE_DWORD, 64'h1111111122222222);
    addr_phase(32'h010, 1'b1, HSIZE_DWORD);
    tick();
    bus_idle();
    hwdata = 64'hFFFFFFFFFFFFFFFF;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    addr_phase(32'h000, 1'b0, HSIZE_DWORD);
    tick();
    bus_idle();
    @(negedge clk);
    n_checks++; if (cur_ready !== 1'b0) begin n_fail++; $display("FAIL rwait_before_reset: got %b expected 0", cur_ready); end
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if ({cur_ready, cur_resp, cur_rdata} !== {1'b1, HRESP_OKAY, 64'h0}) begin n_fail++; $display("FAIL reset_in_rwait: got rdy=%b resp=%b data=%h expected rdy=1 resp=00 data=0", cur_ready, cur_resp, cur_rdata); end
    rst_n = 1'b1;
    tick();
    do_read(32'h010, HSIZE_DWORD, d, w);
    n_checks++; if (d !== 64'h1111111122222222) begin n_fail++; $display("FAIL reset_drops_write: got %h expected 1111111122222222", d); end
  endtask

  initial begin
    test_reset();
    test_write_read_fwd();
    test_byte_merge();
    test_wait_states();
    test_error();
    test_wide_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb2_sram_slv.md
# ahb2_sram_slv

Parametrised AHB2 SRAM slave, successor to the team's fixed 32-bit zero-wait memory model. Adds configurable data width, configurable read wait states, byte/halfword sub-word writes via `hsize`, ERROR responses for illegal transfers, and write-to-read forwarding. It sits on an AHB2 slave port behind the decoder and serves as simulation and FPGA memory for bus masters.

## Interface
Parameters:
- `ADDR_WIDTH`, default 18: byte-address width of the memory. Depth is `2**ADDR_WIDTH / (DATA_WIDTH/8)` words.
- `DATA_WIDTH`, default 32: bus and word width. Legal values are 32 and 64.
- `RD_WAIT`, default 0: number of `hreadyo`-low cycles inserted in each read data phase. Legal range is 0..7.

Ports:
- `clk`, input, 1 bit: clock.
- `rst_n`, input, 1 bit: reset, synchronous, active-low.
- `ahb_if`, `AHB2_SLV_INTF.slave`: carries `hsel`, `haddr`, `htrans`, `hwrite`, `hsize`, `hwdata`, `hreadyi` (inputs) and `hrdata`, `hreadyo`, `hresp` (outputs), with `hrdata`/`hwdata` `DATA_WIDTH` wide.

## Operation
- **Transfer acceptance.** A transfer is accepted on a rising edge where `hsel & htrans[1] & hreadyi` holds. IDLE and BUSY transfers get a zero-wait OKAY.
- **Legality check.** The check is made in the address phase.
  - `hsize` > log2(`DATA_WIDTH`/8) is illegal.
  - A misaligned `haddr` for the given `hsize` is illegal.
  - An illegal transfer produces a two-cycle ERROR: cycle 1 drives `hresp`=ERROR, `hreadyo`=0; cycle 2 drives `hresp`=ERROR, `hreadyo`=1.
  - An illegal transfer never writes memory.
- **Byte lanes.** Lanes are little-endian. The lane base is `haddr[log2(DATA_WIDTH/8)-1:0]` and the size is 2**`hsize` bytes.
- **Write.**
  - The address phase registers `wr_pend`, the word address and the byte-enable mask.
  - The data phase is always zero-wait. `hwdata` enabled lanes commit to memory on the edge ending the data phase.
- **Read.**
  - `hrdata` always returns the full word; unaccessed lanes carry memory content.
  - Data reflects every earlier accepted write.
- **Forwarding.** Applies when a read address phase coincides with a pending write data phase to the same word. Write-enabled lanes come from `hwdata` and the remaining lanes from memory.
- **Read FSM states.**
  - `IDLE`: `hreadyo`=1, OKAY.
  - `RWAIT`: counter runs from `RD_WAIT` down to 1, with `hreadyo`=0.
  - `RDATA`: `hreadyo`=1, `hrdata` valid.
  - `ERR1` and `ERR2`: the two ERROR cycles.
- **FSM transitions.**
  - `IDLE` goes to `RWAIT` on an accepted legal read when `RD_WAIT`>0, otherwise to `RDATA`.
  - `IDLE` goes to `ERR1` on an accepted illegal transfer.
  - `RWAIT` goes to `RDATA` when the count reaches 1. `ERR1` goes to `ERR2`.
  - `RDATA` and `ERR2` accept a new transfer in the same cycle (pipelined), following the same rules as `IDLE`.
- **While `hreadyo`=0.** `hreadyi` is low, so no new address phase is accepted.
- **Write with zero wait.** A write address phase accepted in `IDLE`/`RDATA`/`ERR2` keeps the FSM at `IDLE` for the following data phase.

## Timing
- Reset values: `hreadyo`=1, `hresp`=OKAY, `hrdata`=0, FSM=`IDLE`, `wr_pend`=0, wait counter=0.
- Read latency: data is valid `RD_WAIT`+1 cycles after the address-phase edge. Each read costs `RD_WAIT`+1 data-phase cycles.
- Write latency: the data phase is 1 cycle, and the commit happens at its end.
- `hrdata` outside `RDATA` is 0, not X.
- Back-to-back write then read to the same word with `RD_WAIT`=0 returns the written bytes, through forwarding.
- Back-to-back writes to the same word: the later one wins per lane.
- Address wrap: words are indexed by `haddr[ADDR_WIDTH-1:log2(DW/8)]`. Upper `haddr` bits are ignored, so aliasing wraps.
- Reset mid-transfer: the pending write is discarded and the FSM goes to `IDLE`. Memory content is untouched.

## Structure
- Shared package `ahb2_pkg` holds:
  - `HTRANS_IDLE/BUSY/NONSEQ/SEQ`
  - `HRESP_OKAY/HRESP_ERROR`
  - `HSIZE_BYTE/HALF/WORD/DWORD`
  - `typedef enum` `ahb2_sram_state_t`
- Sub-module `ahb2_sram_array`: a byte-enabled synchronous array with one write port and a combinational read for forwarding.
  - It provides the sim-only tasks `init_mem`, `init_mem_with_addr`, `read_word`, `write_word`, which carry distinct names.
- The top level holds the FSM, legality check, lane decode and forwarding mux.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles, then release -> `hreadyo`=1, `hresp`=OKAY, `hrdata`=0.
- **Word write, then read.** Use `DATA_WIDTH`=32, `RD_WAIT`=0. Write word 0x100 with 0xDEADBEEF, then immediately read 0x100 -> `hrdata`=0xDEADBEEF one cycle after the read address phase, via forwarding.
- **Byte write merge.** Memory 0x104 = 0x11223344. Write byte 0xAA at 0x106 (`hsize`=0), then read 0x104 -> 0x11AA3344.
- **Read wait states.** Use `RD_WAIT`=3. Read 0x200 -> `hreadyo` low for exactly 3 cycles, then high with data. A second read presented meanwhile is not accepted until `RDATA`.
- **Error response.** Issue a halfword write at 0x101 (misaligned) -> ERROR with `hreadyo` 0 then 1, and memory at 0x100 unchanged.
  - With `DATA_WIDTH`=32, a read with `hsize`=3 -> ERROR.
- **64-bit and wrap.** Use `DATA_WIDTH`=64, `ADDR_WIDTH`=10. Write dword at 0x400 (aliases 0x000) -> read at 0x000 returns the written value. Reset asserted during `RWAIT` -> `IDLE`, `hreadyo`=1 next cycle.
